instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- PC-generation and fetch stage directly upstream of the instruction memory: drives the memory byte address, takes back the registered 32-bit word one cycle later, and presents it to decode with a valid/ready handshake.
- Handles branch/jump redirects with zero-bubble address bypass, decode back-pressure via a one-entry skid buffer, and misaligned/out-of-range fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of first fetch after reset
- MEM_BYTES, 1024, instruction memory size in bytes; legal fetch addresses are 0 .. MEM_BYTES-4

Ports:
- Clk  in  1  clock; all state updates on posedge
- Reset  in  1  synchronous, active-high reset
- Imem_Addr  out  32  byte address to instruction memory (combinational)
- Imem_Data  in  32  memory word, registered by memory; valid one cycle after address
- Instr_Valid  out  1  decode-side valid
- Instr_Ready  in  1  decode-side ready
- Instr  out  32  instruction word to decode
- Instr_PC  out  32  byte address of Instr
- Redirect_Valid  in  1  branch/jump taken this cycle
- Redirect_PC  in  32  redirect target
- Fetch_Fault  out  1  fetch halted on illegal address
- Fault_PC  out  32  offending address

Behaviour:
- Clock/reset: one clock, Clk; Reset is synchronous, active-high.
- State: PC, pend_v/pend_pc (request issued last cycle), skid_v/skid_instr/skid_pc, fsm {RUN, FAULT}.
- Reset: PC=RESET_PC, pend_v=0, skid_v=0, fsm=RUN, Fault_PC=0. Outputs after reset: Instr_Valid=0, Instr=32'h0000_0013 (NOP), Instr_PC=0, Fetch_Fault=0. Reset overrides Redirect_Valid.
- Next-address: next_addr = Redirect_Valid ? Redirect_PC : PC. Imem_Addr = next_addr at all times.
- Output mux:
  - skid_v=1 -> Instr=skid_instr, Instr_PC=skid_pc, Instr_Valid=1.
  - Otherwise pend_v=1 -> Instr=Imem_Data, Instr_PC=pend_pc, Instr_Valid=1.
  - Otherwise Instr_Valid=0, Instr=NOP, Instr_PC=0.
  - Instr_Valid is forced 0 (and Instr=NOP) in any cycle with Redirect_Valid=1.
- Invariant: pend_v and skid_v are never both 1.
- fire = Instr_Valid & Instr_Ready.
- legal(a) = a[1:0]==0 and a <= MEM_BYTES-4.
- issue = (fsm==RUN or Redirect_Valid) & (!Instr_Valid | Instr_Ready) & legal(next_addr).
  - On issue: pend_v<=1, pend_pc<=next_addr, PC<=next_addr+4.
  - Otherwise pend_v<=0 and PC holds (PC<=Redirect_PC on a redirect).
- Back-pressure: pend_v & !fire & !Redirect_Valid -> skid_v<=1, skid_instr<=Imem_Data, skid_pc<=pend_pc. skid_v & fire -> skid_v<=0.
- Redirect: squashes pend and skid (both cleared, the in-flight word is dropped) and leaves FAULT for RUN. Target instruction is valid on the next cycle, giving 1-cycle redirect latency.
- Fault: (fsm==RUN or Redirect_Valid) & !legal(next_addr) -> fsm<=FAULT, Fault_PC<=next_addr, no issue.
  - In FAULT: Fetch_Fault=1, no issue; pend/skid drain normally.
  - Exit only via Redirect_Valid to a legal target (illegal target re-enters FAULT with the new Fault_PC) or Reset.
- Throughput: 1 instruction/cycle with Instr_Ready held high; first instruction valid 1 cycle after reset release.
- PC arithmetic: 32-bit, wraps modulo 2^32; wrap produces an illegal address and faults.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs Perf_Fetched (32) and Perf_Stall (32), both reset to 0.
  - Perf_Fetched increments on each fire.
  - Perf_Stall increments on each cycle with Instr_Valid & !Instr_Ready.
  - Both wrap at 2^32 and are not cleared by redirect.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset release, RESET_PC=0, Instr_Ready=1, memory word0=32'h4020_80b3 -> Imem_Addr=0,4,8 on consecutive cycles; the cycle after release gives Instr_Valid=1, Instr=32'h4020_80b3, Instr_PC=0; then one instruction per cycle.
- Instr_Ready low for 3 cycles while PC=8 is in flight -> skid captures word@8; Instr/Instr_PC=8 held stable; Imem_Addr holds 12; no instruction lost or duplicated after Ready returns.
- Redirect_Valid=1, Redirect_PC=0x40 while pend/skid occupied -> Instr_Valid=0 that cycle, Imem_Addr=0x40 same cycle, next cycle Instr_PC=0x40, squashed words never appear.
- Redirect_PC=0x42 -> Fetch_Fault=1, Fault_PC=0x42, no further issues; later redirect to 0x10 -> Fetch_Fault=0, Instr_PC=0x10 next cycle.
- Sequential fetch reaching 0x3FC with MEM_BYTES=1024 -> word@0x3FC delivered, then Fetch_Fault=1, Fault_PC=0x400.
- Reset asserted mid-stall with skid_v=1 and Redirect_Valid=1 -> next cycle Instr_Valid=0, Fetch_Fault=0, Imem_Addr=RESET_PC; with FETCH_PERF_CNT_EN, Perf_Fetched=Perf_Stall=0.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC generation and fetch stage feeding decode.
//
// The stage drives a byte address to an instruction memory whose data comes
// back registered one cycle later, and presents each word to decode with a
// valid/ready handshake. It also handles:
//   - redirects: the redirect target goes straight onto the memory address,
//     so the target word is valid on the following cycle;
//   - decode back-pressure: a one-entry skid buffer holds the in-flight word;
//   - misaligned or out-of-range addresses: fetching halts with a fault.
//
// Optional feature macro: FETCH_PERF_CNT_EN adds the Perf_Fetched and
// Perf_Stall counters.
//
// Ports:
//   Clk            in   clock, posedge
//   Reset          in   synchronous active-high reset
//   Imem_Addr      out  fetch byte address (combinational)
//   Imem_Data      in   memory word for the address of the previous cycle
//   Instr_Valid    out  decode-side valid
//   Instr_Ready    in   decode-side ready
//   Instr          out  instruction word to decode
//   Instr_PC       out  byte address of Instr
//   Redirect_Valid in   branch/jump taken this cycle
//   Redirect_PC    in   redirect target
//   Fetch_Fault    out  fetch halted on an illegal address
//   Fault_PC       out  offending address
//   Perf_Fetched   out  count of accepted instructions   (FETCH_PERF_CNT_EN)
//   Perf_Stall     out  count of valid-but-stalled cycles (FETCH_PERF_CNT_EN)
//
// State table:
//   RUN   | issuing sequential fetches
//   FAULT | halted on an illegal address, waiting for a legal redirect
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] Imem_Addr,
  input  logic [31:0] Imem_Data,
  output logic        Instr_Valid,
  input  logic        Instr_Ready,
  output logic [31:0] Instr,
  output logic [31:0] Instr_PC,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_PC,
  output logic        Fetch_Fault,
  output logic [31:0] Fault_PC
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] Perf_Fetched,
  output logic [31:0] Perf_Stall
`endif
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

  typedef enum logic {RUN, FAULT} fsm_t;

  fsm_t        fsm, fsm_next;
  logic [31:0] pc;
  logic        pend_v;
  logic [31:0] pend_pc;
  logic        skid_v;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic [31:0] next_addr;
  logic        addr_legal;
  logic        active;
  logic        fire;
  logic        issue;
  logic        fault_set;

  assign next_addr  = Redirect_Valid ? Redirect_PC : pc;
  assign Imem_Addr  = next_addr;
  assign addr_legal = (next_addr[1:0] == 2'b00) && (next_addr <= LAST_ADDR);
  assign active     = (fsm == RUN) || Redirect_Valid;
  assign fault_set  = active && !addr_legal;
  assign Fetch_Fault = (fsm == FAULT);

  // Skid has priority over the pending word; a redirect hides whatever is
  // queued because it is about to be squashed.
  always_comb begin
    Instr_Valid = 1'b0;
    Instr       = NOP;
    Instr_PC    = 32'h0;
    if (!Redirect_Valid) begin
      if (skid_v) begin
        Instr_Valid = 1'b1;
        Instr       = skid_instr;
        Instr_PC    = skid_pc;
      end else if (pend_v) begin
        Instr_Valid = 1'b1;
        Instr       = Imem_Data;
        Instr_PC    = pend_pc;
      end
    end
  end

  assign fire  = Instr_Valid && Instr_Ready;
  // Only issue when the word now in flight has somewhere to go next cycle.
  assign issue = active && (!Instr_Valid || Instr_Ready) && addr_legal;

  always_comb begin
    fsm_next = fsm;
    if (fault_set)
      fsm_next = FAULT;
    else if (Redirect_Valid)
      fsm_next = RUN;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fsm        <= RUN;
      pc         <= RESET_PC;
      pend_v     <= 1'b0;
      pend_pc    <= 32'h0;
      skid_v     <= 1'b0;
      skid_instr <= 32'h0;
      skid_pc    <= 32'h0;
      Fault_PC   <= 32'h0;
    end else begin
      fsm    <= fsm_next;
      pend_v <= issue;
      if (issue) begin
        pend_pc <= next_addr;
        pc      <= next_addr + 32'd4;
      end else if (Redirect_Valid) begin
        pc <= Redirect_PC;
      end

      if (fault_set)
        Fault_PC <= next_addr;

      if (Redirect_Valid) begin
        skid_v <= 1'b0;
      end else if (pend_v && !fire) begin
        // Memory data is only valid for one cycle; park it here.
        skid_v     <= 1'b1;
        skid_instr <= Imem_Data;
        skid_pc    <= pend_pc;
      end else if (skid_v && fire) begin
        skid_v <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Perf_Fetched <= 32'h0;
      Perf_Stall   <= 32'h0;
    end else begin
      if (fire)
        Perf_Fetched <= Perf_Fetched + 32'd1;
      if (Instr_Valid && !Instr_Ready)
        Perf_Stall <= Perf_Stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Imem_Addr;
  logic [31:0] Imem_Data = 32'h0;
  logic        Instr_Valid;
  logic        Instr_Ready;
  logic [31:0] Instr;
  logic [31:0] Instr_PC;
  logic        Redirect_Valid;
  logic [31:0] Redirect_PC;
  logic        Fetch_Fault;
  logic [31:0] Fault_PC;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] Perf_Fetched;
  logic [31:0] Perf_Stall;
`endif

  int checks   = 0;
  int failures = 0;

  instruction_fetch #(.RESET_PC(32'h0), .MEM_BYTES(1024)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Imem_Addr      (Imem_Addr),
    .Imem_Data      (Imem_Data),
    .Instr_Valid    (Instr_Valid),
    .Instr_Ready    (Instr_Ready),
    .Instr          (Instr),
    .Instr_PC       (Instr_PC),
    .Redirect_Valid (Redirect_Valid),
    .Redirect_PC    (Redirect_PC),
    .Fetch_Fault    (Fetch_Fault),
    .Fault_PC       (Fault_PC)
`ifdef FETCH_PERF_CNT_EN
    ,
    .Perf_Fetched   (Perf_Fetched),
    .Perf_Stall     (Perf_Stall)
`endif
  );

  always #5 Clk = ~Clk;

  // Memory contents: word 0 is the test-plan word, others tag their address.
  function automatic logic [31:0] mw(input logic [31:0] a);
    return (a == 32'h0) ? 32'h4020_80b3 : (32'hA5A5_0000 | a);
  endfunction

  // Registered instruction memory: data appears one cycle after the address.
  always @(posedge Clk) Imem_Data <= mw(Imem_Addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1; Instr_Ready = 1'b1; Redirect_Valid = 1'b0; Redirect_PC = 32'h0;
    tick; tick;
    #1;
    chk("rst_valid", {31'h0, Instr_Valid}, 32'h0);
    chk("rst_instr", Instr, NOP);
    chk("rst_pc", Instr_PC, 32'h0);
    chk("rst_fault", {31'h0, Fetch_Fault}, 32'h0);
    chk("rst_faultpc", Fault_PC, 32'h0);
    chk("rst_addr", Imem_Addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_f", Perf_Fetched, 32'h0);
    chk("rst_perf_s", Perf_Stall, 32'h0);
`endif

    // c0: release
    Reset = 1'b0; #1;
    chk("c0_addr", Imem_Addr, 32'h0);
    chk("c0_valid", {31'h0, Instr_Valid}, 32'h0);
    // c1: first instruction
    tick;
    chk("c1_valid", {31'h0, Instr_Valid}, 32'h1);
    chk("c1_instr", Instr, 32'h4020_80b3);
    chk("c1_pc", Instr_PC, 32'h0);
    chk("c1_addr", Imem_Addr, 32'h4);
    // c2
    tick;
    chk("c2_pc", Instr_PC, 32'h4);
    chk("c2_instr", Instr, mw(32'h4));
    chk("c2_addr", Imem_Addr, 32'h8);
    // c3..c5: ready low with PC=8 in flight
    tick;
    Instr_Ready = 1'b0; #1;
    chk("c3_pc", Instr_PC, 32'h8);
    chk("c3_addr", Imem_Addr, 32'hC);
    tick;
    chk("c4_valid", {31'h0, Instr_Valid}, 32'h1);
    chk("c4_pc", Instr_PC, 32'h8);
    chk("c4_instr", Instr, mw(32'h8));
    chk("c4_addr", Imem_Addr, 32'hC);
    tick;
    chk("c5_pc", Instr_PC, 32'h8);
    chk("c5_instr", Instr, mw(32'h8));
    chk("c5_addr", Imem_Addr, 32'hC);
    // c6: ready returns, skid word accepted
    tick;
    Instr_Ready = 1'b1; #1;
    chk("c6_pc", Instr_PC, 32'h8);
    chk("c6_instr", Instr, mw(32'h8));
    chk("c6_addr", Imem_Addr, 32'hC);
    // c7: next word, no loss/dup; stall again to fill skid
    tick;
    chk("c7_pc", Instr_PC, 32'hC);
    chk("c7_instr", Instr, mw(32'hC));
    chk("c7_addr", Imem_Addr, 32'h10);
    Instr_Ready = 1'b0;
    // c8: skid full, redirect to 0x40
    tick;
    chk("c8_skid_pc", Instr_PC, 32'hC);
    chk("c8_skid_instr", Instr, mw(32'hC));
    Redirect_Valid = 1'b1; Redirect_PC = 32'h40; Instr_Ready = 1'b1; #1;
    chk("c8_rd_valid", {31'h0, Instr_Valid}, 32'h0);
    chk("c8_rd_instr", Instr, NOP);
    chk("c8_rd_addr", Imem_Addr, 32'h40);
    // c9: target valid
    tick;
    Redirect_Valid = 1'b0; #1;
    chk("c9_valid", {31'h0, Instr_Valid}, 32'h1);
    chk("c9_pc", Instr_PC, 32'h40);
    chk("c9_instr", Instr, mw(32'h40));
    chk("c9_addr", Imem_Addr, 32'h44);
    // c10: redirect to misaligned 0x42
    tick;
    chk("c10_pc", Instr_PC, 32'h44);
    Redirect_Valid = 1'b1; Redirect_PC = 32'h42; #1;
    chk("c10_addr", Imem_Addr, 32'h42);
    chk("c10_fault", {31'h0, Fetch_Fault}, 32'h0);
    // c11, c12: halted
    tick;
    Redirect_Valid = 1'b0; #1;
    chk("c11_fault", {31'h0, Fetch_Fault}, 32'h1);
    chk("c11_faultpc", Fault_PC, 32'h42);
    chk("c11_valid", {31'h0, Instr_Valid}, 32'h0);
    tick;
    chk("c12_valid", {31'h0, Instr_Valid}, 32'h0);
    chk("c12_fault", {31'h0, Fetch_Fault}, 32'h1);
    Redirect_Valid = 1'b1; Redirect_PC = 32'h10; #1;
    chk("c12_addr", Imem_Addr, 32'h10);
    // c13: recovered
    tick;
    Redirect_Valid = 1'b0; #1;
    chk("c13_fault", {31'h0, Fetch_Fault}, 32'h0);
    chk("c13_valid", {31'h0, Instr_Valid}, 32'h1);
    chk("c13_pc", Instr_PC, 32'h10);
    chk("c13_instr", Instr, mw(32'h10));
    Redirect_Valid = 1'b1; Redirect_PC = 32'h3F8; #1;
    // c14..c16: run off the end of memory
    tick;
    Redirect_Valid = 1'b0; #1;
    chk("c14_pc", Instr_PC, 32'h3F8);
    chk("c14_addr", Imem_Addr, 32'h3FC);
    tick;
    chk("c15_pc", Instr_PC, 32'h3FC);
    chk("c15_instr", Instr, mw(32'h3FC));
    chk("c15_fault", {31'h0, Fetch_Fault}, 32'h0);
    chk("c15_addr", Imem_Addr, 32'h400);
    tick;
    chk("c16_fault", {31'h0, Fetch_Fault}, 32'h1);
    chk("c16_faultpc", Fault_PC, 32'h400);
    chk("c16_valid", {31'h0, Instr_Valid}, 32'h0);
    Redirect_Valid = 1'b1; Redirect_PC = 32'h20; #1;
    // c17, c18: fill skid, then reset with redirect
    tick;
    Redirect_Valid = 1'b0; Instr_Ready = 1'b0; #1;
    chk("c17_pc", Instr_PC, 32'h20);
    chk("c17_fault", {31'h0, Fetch_Fault}, 32'h0);
    tick;
    chk("c18_skid_pc", Instr_PC, 32'h20);
    chk("c18_skid_instr", Instr, mw(32'h20));
    Reset = 1'b1; Redirect_Valid = 1'b1; Redirect_PC = 32'h80; #1;
    // c19: reset won over redirect
    tick;
    Reset = 1'b0; Redirect_Valid = 1'b0; Instr_Ready = 1'b1; #1;
    chk("c19_valid", {31'h0, Instr_Valid}, 32'h0);
    chk("c19_fault", {31'h0, Fetch_Fault}, 32'h0);
    chk("c19_addr", Imem_Addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("c19_perf_f", Perf_Fetched, 32'h0);
    chk("c19_perf_s", Perf_Stall, 32'h0);
`endif
    tick;
    chk("c20_valid", {31'h0, Instr_Valid}, 32'h1);
    chk("c20_pc", Instr_PC, 32'h0);
    chk("c20_instr", Instr, 32'h4020_80b3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
